// File: rtl/video_window_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : video_window_gen_if
//  Purpose  : Pixel-stream bundle between a video source, the sliding-window
//             generator and the stage consuming its window.
//  Revision : 1.0  initial release
// ============================================================================
interface video_window_gen_if #(
   parameter int KSIZE    = 3,
   parameter int DATA_W   = 8,
   parameter int CHANNELS = 3,
   parameter int CNT_W    = 12
) ();
   logic [CHANNELS*DATA_W-1:0]             in_data;
   logic                                   in_dv;
   logic                                   in_hs;
   logic                                   in_vs;
   logic [KSIZE*KSIZE*CHANNELS*DATA_W-1:0] win_data;
   logic                                   out_dv;
   logic                                   out_hs;
   logic                                   out_vs;
   logic [CNT_W-1:0]                       out_row;
   logic [CNT_W-1:0]                       out_col;
   logic [CNT_W-1:0]                       line_len;
   logic                                   ovf;

   // Video source side: drives the pixel stream, observes the window.
   modport master (
      output in_data, in_dv, in_hs, in_vs,
      input  win_data, out_dv, out_hs, out_vs, out_row, out_col, line_len, ovf
   );

   // Window generator side.
   modport slave (
      input  in_data, in_dv, in_hs, in_vs,
      output win_data, out_dv, out_hs, out_vs, out_row, out_col, line_len, ovf
   );
endinterface
`default_nettype wire

// File: rtl/video_window_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : video_window_gen
//  Purpose  : KSIZE x KSIZE sliding-window generator with KSIZE-1 chained line
//             buffers, sync/position delay matching, line-length measurement
//             and sticky line-buffer overflow flag.
//  Options  : VIDEO_WINDOW_ZERO_BORDER_EN - zero taps above/left of the frame.
//  Revision : 1.0  initial release
// ============================================================================
module video_window_gen #(
   parameter int KSIZE    = 3,
   parameter int DATA_W   = 8,
   parameter int CHANNELS = 3,
   parameter int MAX_LINE = 2048,
   parameter int CNT_W    = 12
) (
   input wire                clk,
   input wire                rst,
   video_window_gen_if.slave bus
);
   localparam int c_PIX_W = CHANNELS * DATA_W;
   localparam int c_TAPS  = KSIZE * KSIZE;
   localparam int c_NBUF  = KSIZE - 1;
   localparam int c_AW    = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;
   localparam logic [CNT_W-1:0] c_MAX = CNT_W'(MAX_LINE);

   // Input-side counters and edge detectors
   logic [CNT_W-1:0]   r_col;
   logic [CNT_W-1:0]   r_row;
   logic [CNT_W-1:0]   r_line_len;
   logic               r_ovf;
   logic               r_dv_q;
   logic               r_vs_q;

   // Stage 1: aligned with the line-buffer read data
   logic [c_PIX_W-1:0] r_d1_data;
   logic               r_d1_dv;
   logic               r_d1_hs;
   logic               r_d1_vs;
   logic [CNT_W-1:0]   r_d1_row;
   logic [CNT_W-1:0]   r_d1_col;

   // Stage 2: window and delayed sync/position
   logic [c_PIX_W-1:0] r_win [0:c_TAPS-1];
   logic               r_out_dv;
   logic               r_out_hs;
   logic               r_out_vs;
   logic [CNT_W-1:0]   r_out_row;
   logic [CNT_W-1:0]   r_out_col;

   logic [c_AW-1:0]    w_addr;
   logic               w_wr;
   logic               w_line_end;
   logic               w_vs_rise;
   logic [c_PIX_W-1:0] w_lb_rd [0:c_NBUF-1];  // same-cycle (old) contents
   logic [c_PIX_W-1:0] w_lb_q  [0:c_NBUF-1];  // registered read data
   logic [c_PIX_W-1:0] w_newcol [0:KSIZE-1];

   // Column counter saturates at MAX_LINE, so that value marks an overflowed pixel.
   assign w_addr     = r_col[c_AW-1:0];
   assign w_wr       = bus.in_dv && (r_col != c_MAX);
   assign w_line_end = !bus.in_dv && r_dv_q;
   assign w_vs_rise  = bus.in_vs && !r_vs_q;

   // Line buffers: buffer 0 takes the new pixel, buffer n takes the old word of n-1.
   for (genvar n = 0; n < c_NBUF; n++) begin : g_lbuf
      logic [c_PIX_W-1:0] r_mem [0:MAX_LINE-1];
      logic [c_PIX_W-1:0] r_q;
      logic [c_PIX_W-1:0] w_wdata;

      if (n == 0) begin : g_head
         assign w_wdata = bus.in_data;
      end else begin : g_chain
         assign w_wdata = w_lb_rd[n-1];
      end

      assign w_lb_rd[n] = r_mem[w_addr];
      assign w_lb_q[n]  = r_q;

      // Read-before-write at the column address; contents are never reset.
      always_ff @(posedge clk) begin
         if (w_wr) begin
            r_q           <= r_mem[w_addr];
            r_mem[w_addr] <= w_wdata;
         end
      end
   end

   // Incoming column: oldest line (last buffer) at the top, live pixel at the bottom.
   for (genvar r = 0; r < KSIZE - 1; r++) begin : g_newcol
      assign w_newcol[r] = w_lb_q[KSIZE-2-r];
   end
   assign w_newcol[KSIZE-1] = r_d1_data;

   // Column/row counters, line length measurement and sticky overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col      <= '0;
         r_row      <= '0;
         r_line_len <= '0;
         r_ovf      <= 1'b0;
         r_dv_q     <= 1'b0;
         r_vs_q     <= 1'b0;
      end else begin
         r_dv_q <= bus.in_dv;
         r_vs_q <= bus.in_vs;
         if (bus.in_dv) begin
            if (r_col == c_MAX) begin
               r_ovf <= 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end else if (r_dv_q) begin
            r_col      <= '0;
            r_line_len <= r_col;
         end
         // A frame start overrides a coincident line end.
         if (w_vs_rise) begin
            r_row <= '0;
         end else if (w_line_end) begin
            r_row <= r_row + 1'b1;
         end
      end
   end

   // First delay stage, matching the line-buffer read latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_d1_data <= '0;
         r_d1_dv   <= 1'b0;
         r_d1_hs   <= 1'b0;
         r_d1_vs   <= 1'b0;
         r_d1_row  <= '0;
         r_d1_col  <= '0;
      end else begin
         r_d1_data <= bus.in_data;
         r_d1_dv   <= bus.in_dv;
         r_d1_hs   <= bus.in_hs;
         r_d1_vs   <= bus.in_vs;
         r_d1_row  <= r_row;
         r_d1_col  <= r_col;
      end
   end

   // Window shifts left one column per valid pixel and holds during blanking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int t = 0; t < c_TAPS; t++) begin
            r_win[t] <= '0;
         end
      end else if (r_d1_dv) begin
         for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE - 1; c++) begin
               r_win[r*KSIZE+c] <= r_win[r*KSIZE+c+1];
            end
            r_win[r*KSIZE+KSIZE-1] <= w_newcol[r];
         end
      end
   end

   // Second delay stage for sync and position, aligned with the window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_dv  <= 1'b0;
         r_out_hs  <= 1'b0;
         r_out_vs  <= 1'b0;
         r_out_row <= '0;
         r_out_col <= '0;
      end else begin
         r_out_dv  <= r_d1_dv;
         r_out_hs  <= r_d1_hs;
         r_out_vs  <= r_d1_vs;
         r_out_row <= r_d1_row;
         r_out_col <= r_d1_col;
      end
   end

   // Window output, optionally masking taps that fall above or left of the frame.
   for (genvar t = 0; t < c_TAPS; t++) begin : g_tap
`ifdef VIDEO_WINDOW_ZERO_BORDER_EN
      localparam logic [CNT_W:0] c_RA  = (CNT_W+1)'(t / KSIZE);
      localparam logic [CNT_W:0] c_CA  = (CNT_W+1)'(t % KSIZE);
      localparam logic [CNT_W:0] c_LIM = (CNT_W+1)'(KSIZE - 1);
      logic w_keep;
      assign w_keep = (({1'b0, r_out_row} + c_RA) >= c_LIM) &&
                      (({1'b0, r_out_col} + c_CA) >= c_LIM);
      assign bus.win_data[t*c_PIX_W +: c_PIX_W] = w_keep ? r_win[t] : '0;
`else
      assign bus.win_data[t*c_PIX_W +: c_PIX_W] = r_win[t];
`endif
   end

   assign bus.out_dv   = r_out_dv;
   assign bus.out_hs   = r_out_hs;
   assign bus.out_vs   = r_out_vs;
   assign bus.out_row  = r_out_row;
   assign bus.out_col  = r_out_col;
   assign bus.line_len = r_line_len;
   assign bus.ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_video_window_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_video_window_gen
//  Purpose  : Directed self-checking bench for video_window_gen (KSIZE=3,
//             3x8-bit channels, MAX_LINE=8, 8-pixel lines).
//  Revision : 1.0  initial release
// ============================================================================
module tb_video_window_gen;
   localparam int c_K  = 3;
   localparam int c_DW = 8;
   localparam int c_CH = 3;
   localparam int c_ML = 8;
   localparam int c_CW = 12;
   localparam int c_PW = c_DW * c_CH;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;

   video_window_gen_if #(.KSIZE(c_K), .DATA_W(c_DW), .CHANNELS(c_CH), .CNT_W(c_CW)) vif ();

   video_window_gen #(
      .KSIZE(c_K), .DATA_W(c_DW), .CHANNELS(c_CH), .MAX_LINE(c_ML), .CNT_W(c_CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(vif)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Pixel value 0x40+row*16+col on channel 0, distinct derivatives on 1 and 2.
   function automatic logic [31:0] pix(input int r, input int c);
      logic [7:0] v;
      v = 8'(32'h40 + r * 16 + c);
      return {8'h00, v ^ 8'h0F, ~v, v};
   endfunction

   function automatic logic [31:0] tap(input int r, input int c);
      return 32'(vif.win_data[(r*c_K+c)*c_PW +: c_PW]);
   endfunction

   // Drive one cycle of input, then step to just after the next rising edge.
   task automatic cyc(input logic dv, input logic hs, input logic vs, input logic [31:0] d);
      vif.in_dv   = dv;
      vif.in_hs   = hs;
      vif.in_vs   = vs;
      vif.in_data = d[c_PW-1:0];
      @(posedge clk);
      #1;
   endtask

   logic [31:0] e [0:8];

   initial begin
      rst         = 1'b1;
      vif.in_dv   = 1'b0;
      vif.in_hs   = 1'b0;
      vif.in_vs   = 1'b0;
      vif.in_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_out_dv",   32'(vif.out_dv),   32'd0);
      check_val("rst_out_row",  32'(vif.out_row),  32'd0);
      check_val("rst_line_len", 32'(vif.line_len), 32'd0);
      check_val("rst_ovf",      32'(vif.ovf),      32'd0);
      check_val("rst_tap22",    tap(2, 2),         32'd0);
      rst = 1'b0;
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);

      // Frame 1: four 8-pixel lines; in_vs rises together with the last line end.
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 8; c++) begin
            cyc(1, 0, 0, pix(r, c));
            if (r == 2 && c == 3) begin
               check_val("f1_out_dv",  32'(vif.out_dv),  32'd1);
               check_val("f1_out_row", 32'(vif.out_row), 32'd2);
               check_val("f1_out_col", 32'(vif.out_col), 32'd2);
               for (int tr = 0; tr < 3; tr++) begin
                  for (int tc = 0; tc < 3; tc++) begin
                     check_val($sformatf("f1_tap%0d%0d", tr, tc), tap(tr, tc), pix(tr, tc));
                  end
               end
            end
         end
         cyc(0, 0, (r == 3), 0);
         if (r == 1) begin
            cyc(0, 1, 0, 0);
            check_val("hs_d1", 32'(vif.out_hs), 32'd0);
            cyc(0, 0, 0, 0);
            check_val("hs_d2", 32'(vif.out_hs), 32'd1);
            cyc(0, 0, 0, 0);
            check_val("hs_d3", 32'(vif.out_hs), 32'd0);
         end
         repeat (3) cyc(0, 0, (r == 3), 0);
      end
      repeat (2) cyc(0, 0, 0, 0);

      // Frame 2, line 0: window at pixel (0,1) exercises the border.
`ifdef VIDEO_WINDOW_ZERO_BORDER_EN
      for (int t = 0; t < 9; t++) e[t] = 32'd0;
      e[7] = pix(0, 0);
      e[8] = pix(0, 1);
`else
      e[0] = pix(1, 7); e[1] = pix(2, 0); e[2] = pix(2, 1);
      e[3] = pix(2, 7); e[4] = pix(3, 0); e[5] = pix(3, 1);
      e[6] = pix(3, 7); e[7] = pix(0, 0); e[8] = pix(0, 1);
`endif
      for (int c = 0; c < 8; c++) begin
         cyc(1, 0, 0, pix(0, c));
         if (c == 2) begin
            check_val("f2_out_row", 32'(vif.out_row), 32'd0);
            check_val("f2_out_col", 32'(vif.out_col), 32'd1);
            for (int t = 0; t < 9; t++) begin
               check_val($sformatf("f2_tap%0d%0d", t / 3, t % 3), tap(t / 3, t % 3), e[t]);
            end
         end
      end
      repeat (3) cyc(0, 0, 0, 0);

      // Short line: line length measurement.
      for (int c = 0; c < 5; c++) cyc(1, 0, 0, pix(1, c));
      repeat (2) cyc(0, 0, 0, 0);
      check_val("len_short", 32'(vif.line_len), 32'd5);

      // 10-pixel line overruns an 8-deep buffer on its 9th pixel.
      for (int c = 0; c < 10; c++) begin
         cyc(1, 0, 0, pix(2, c));
         if (c == 7) check_val("ovf_pix8", 32'(vif.ovf), 32'd0);
         if (c == 8) check_val("ovf_pix9", 32'(vif.ovf), 32'd1);
      end
      repeat (2) cyc(0, 0, 0, 0);
      check_val("len_sat", 32'(vif.line_len), 32'd8);

      // Following normal line: window content must be intact.
      for (int c = 0; c < 8; c++) begin
         cyc(1, 0, 0, pix(3, c));
         if (c == 1) begin
            check_val("post_tap12_c0", tap(1, 2), pix(2, 0));
            check_val("post_tap22_c0", tap(2, 2), pix(3, 0));
         end
         if (c == 5) begin
            check_val("post_tap22", tap(2, 2), pix(3, 4));
            check_val("post_tap12", tap(1, 2), pix(2, 4));
            check_val("post_tap02", tap(0, 2), pix(1, 4));
            check_val("post_tap11", tap(1, 1), pix(2, 3));
            check_val("post_row",   32'(vif.out_row), 32'd3);
            check_val("post_col",   32'(vif.out_col), 32'd4);
            check_val("ovf_sticky", 32'(vif.ovf), 32'd1);
         end
      end
      repeat (2) cyc(0, 0, 0, 0);

      // Asynchronous reset in the middle of an active line.
      cyc(1, 0, 0, pix(4, 0));
      cyc(1, 0, 0, pix(4, 1));
      cyc(1, 0, 0, pix(4, 2));
      rst = 1'b1;
      #1;
      check_val("mrst_out_dv",   32'(vif.out_dv),   32'd0);
      check_val("mrst_out_row",  32'(vif.out_row),  32'd0);
      check_val("mrst_out_col",  32'(vif.out_col),  32'd0);
      check_val("mrst_line_len", 32'(vif.line_len), 32'd0);
      check_val("mrst_ovf",      32'(vif.ovf),      32'd0);
      check_val("mrst_tap00",    tap(0, 0),         32'd0);
      check_val("mrst_tap22",    tap(2, 2),         32'd0);
      vif.in_dv = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc(0, 0, 0, 0);
      cyc(1, 0, 0, pix(0, 0));
      cyc(1, 0, 0, pix(0, 1));
      check_val("rel_out_dv",  32'(vif.out_dv),  32'd1);
      check_val("rel_out_row", 32'(vif.out_row), 32'd0);
      check_val("rel_out_col", 32'(vif.out_col), 32'd0);
      check_val("rel_tap22",   tap(2, 2),        pix(0, 0));
      repeat (2) cyc(0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
